// File: rtl/mem_arbiter_pkg.sv
// Shared types and bus widths for the IFU/LSU memory arbiter.
// The FSM state, owner encoding and grant bit positions live here so every block agrees on them.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASK_W   = 4;
  localparam int unsigned STREAK_W = 4;
  localparam int unsigned CNT_W    = 8;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned GNT_IFU = 0;
  localparam int unsigned GNT_LSU = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between IFU and LSU.
// LSU has fixed priority unless its contested streak is full, then the IFU wins once.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_req,
  input  logic       streak_full,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (ifu_req && lsu_req) begin
      if (streak_full) begin
        grant[GNT_IFU] = 1'b1;
      end else begin
        grant[GNT_LSU] = 1'b1;
      end
    end else if (ifu_req) begin
      grant[GNT_IFU] = 1'b1;
    end else if (lsu_req) begin
      grant[GNT_LSU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master / one-slave SimpleBus arbiter: one transaction at a time, LSU priority with an
// IFU anti-starvation streak limit, and a response watchdog that completes with an error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              resp_err,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t          state;
  owner_t              owner;
  logic [STREAK_W-1:0] streak;
  logic [CNT_W-1:0]    cnt;
  logic                streak_full;
  logic [1:0]          grant;
  logic                timed_out;

  assign streak_full = (streak == STREAK_W'(MAX_LSU_STREAK));
  assign timed_out   = (cnt == CNT_W'(TIMEOUT - 1));

  mem_arb_pick u_pick (
    .ifu_req     (ifu_req_valid),
    .lsu_req     (lsu_req_valid),
    .streak_full (streak_full),
    .grant       (grant)
  );

  // Readies are forced low during reset so nothing can be accepted while the FSM is held.
  always_comb begin
    ifu_req_ready = !rst && (state == IDLE) && grant[GNT_IFU];
    lsu_req_ready = !rst && (state == IDLE) && grant[GNT_LSU];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= OWN_IFU;
      streak         <= '0;
      cnt            <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      resp_err       <= 1'b0;
    end else begin
      // Response outputs are only non-zero for the single DONE cycle.
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      resp_err       <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant[GNT_IFU]) begin
            state         <= REQ;
            owner         <= OWN_IFU;
            mem_req_valid <= 1'b1;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            streak        <= '0;
          end else if (grant[GNT_LSU]) begin
            state         <= REQ;
            owner         <= OWN_LSU;
            mem_req_valid <= 1'b1;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            if (ifu_req_valid && !streak_full) begin
              streak <= streak + STREAK_W'(1);
            end
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            state         <= RESP;
            mem_req_valid <= 1'b0;
            cnt           <= '0;
          end
        end

        RESP: begin
          if (mem_resp_valid || timed_out) begin
            state    <= DONE;
            resp_err <= !mem_resp_valid;
            if (owner == OWN_IFU) begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= mem_resp_valid ? mem_rdata : '0;
            end else begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= (mem_resp_valid && !mem_wen) ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small negedge-driven memory model.
// Built with MAX_LSU_STREAK = 4 and TIMEOUT = 8.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;

  logic        resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_LSU_STREAK (4),
    .TIMEOUT        (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model knobs, written only by the main process.
  int          ready_delay = 0;
  bit          resp_en     = 1'b1;
  logic [31:0] resp_data   = '0;
  int          inject_req  = 0;

  int inject_done = 0;
  int wait_cnt    = 0;
  bit pending     = 1'b0;

  // Accept after ready_delay REQ cycles, answer in the first RESP cycle when resp_en is set.
  always @(negedge clk) begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'hA5A5_A5A5;
    if (rst) begin
      wait_cnt = 0;
      pending  = 1'b0;
    end else if (inject_req != inject_done) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h1234_5678;
      inject_done    = inject_req;
    end else if (pending) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = resp_data;
      pending        = 1'b0;
    end else if (mem_req_valid) begin
      if (wait_cnt >= ready_delay) begin
        mem_req_ready = 1'b1;
        pending       = resp_en;
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Grant log: 0 = IFU, 1 = LSU.
  int grants[$];
  always @(negedge clk) begin
    #2;
    if (ifu_req_ready) grants.push_back(0);
    if (lsu_req_ready) grants.push_back(1);
  end

  task automatic wait_resp(input bit lsu, input int budget, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      seen = lsu ? lsu_resp_valid : ifu_resp_valid;
    end
    check(lsu ? "lsu_resp_seen" : "ifu_resp_seen", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hang, want completion");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset: readies forced low even with both requesting, registered outputs 0.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    check("rst_ifu_ready", ifu_req_ready, 0);
    check("rst_lsu_ready", lsu_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_ifu_resp", ifu_resp_valid, 0);
    repeat (2) @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // IFU-only read, minimum latency.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    resp_data     = 32'h0000_0413;
    #1;
    check("t1_ifu_ready", ifu_req_ready, 1);
    check("t1_lsu_ready", lsu_req_ready, 0);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    check("t1_mem_req_valid", mem_req_valid, 1);
    check("t1_mem_addr", mem_addr, 32'h8000_0000);
    check("t1_mem_wen", mem_wen, 0);
    check("t1_mem_wmask", mem_wmask, 0);
    @(negedge clk);
    #1;
    check("t1_req_dropped", mem_req_valid, 0);
    check("t1_no_early_resp", ifu_resp_valid, 0);
    @(negedge clk);
    #1;
    check("t1_ifu_resp", ifu_resp_valid, 1);
    check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("t1_err", resp_err, 0);
    check("t1_lsu_resp", lsu_resp_valid, 0);
    @(negedge clk);
    #1;
    check("t1_resp_pulse", ifu_resp_valid, 0);
    check("t1_rdata_cleared", ifu_rdata, 0);

    // LSU store, memory ready after 3 extra cycles; fields must stay latched.
    ready_delay   = 3;
    resp_data     = 32'h5555_5555;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'b1111;
    #1;
    check("t2_lsu_ready", lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    #1;
    check("t2_mem_wen", mem_wen, 1);
    check("t2_mem_wmask", mem_wmask, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t2_req_held%0d", i), mem_req_valid, 1);
      check($sformatf("t2_wdata_held%0d", i), mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("t2_addr_held%0d", i), mem_addr, 32'h8000_1000);
    end
    wait_resp(1'b1, 10, n);
    check("t2_latency", n, 2);
    check("t2_lsu_rdata", lsu_rdata, 0);
    check("t2_err", resp_err, 0);
    check("t2_ifu_resp", ifu_resp_valid, 0);
    @(negedge clk);
    #1;
    check("t2_resp_pulse", lsu_resp_valid, 0);

    // Contention: LSU x4, IFU, LSU x4, IFU.
    ready_delay = 0;
    resp_data   = 32'h0000_1111;
    grants.delete();
    lsu_addr      = 32'h8000_3000;
    ifu_addr      = 32'h8000_0010;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (40) @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_grant_count", grants.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_grant%0d", i), (i < grants.size()) ? grants[i] : 32'hFFFF_FFFF,
            (i == 4 || i == 9) ? 0 : 1);
    end

    // Timeout: memory never responds, then a late response must be ignored.
    resp_en       = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    #1;
    check("t4_lsu_ready", lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    wait_resp(1'b1, 20, n);
    check("t4_latency", n, 9);
    check("t4_err", resp_err, 1);
    check("t4_rdata", lsu_rdata, 0);
    #2;
    inject_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t4_late_lsu%0d", i), lsu_resp_valid, 0);
      check($sformatf("t4_late_ifu%0d", i), ifu_resp_valid, 0);
      check($sformatf("t4_late_err%0d", i), resp_err, 0);
    end

    // Asynchronous reset in the middle of RESP.
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_4000;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    rst           = 1'b1;
    #1;
    check("t5_ifu_ready", ifu_req_ready, 0);
    check("t5_lsu_ready", lsu_req_ready, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_req_valid", mem_req_valid, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t5_no_resp%0d", i), lsu_resp_valid, 0);
    end
    @(negedge clk);
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    resp_en       = 1'b1;
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    resp_data     = 32'h0010_0093;
    #1;
    check("t5_ifu_ready_after", ifu_req_ready, 1);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    check("t5_mem_addr_after", mem_addr, 32'h8000_0004);
    wait_resp(1'b0, 10, n);
    check("t5_latency", n, 2);
    check("t5_ifu_rdata", ifu_rdata, 32'h0010_0093);
    check("t5_err", resp_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single SimpleBus memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the IFU/LSU and the memory model.
- Serialises transactions one at a time; fixed LSU priority with an anti-starvation limit for the IFU.
- Response timeout watchdog returns an error instead of hanging the core.

Parameters:
MAX_LSU_STREAK, 4, consecutive contested LSU grants after which a contested IFU request wins (1..15)
TIMEOUT, 255, max RESP-state cycles without mem_resp_valid before error completion (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  32  IFU read byte address
ifu_resp_valid  out  1  one-cycle pulse, IFU read data valid
ifu_rdata  out  32  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  32  LSU byte address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  32  LSU write data, lane-aligned
lsu_wmask  in  4  LSU byte write mask
lsu_resp_valid  out  1  one-cycle pulse, LSU transaction complete
lsu_rdata  out  32  LSU read data (0 for writes)
resp_err  out  1  qualifies whichever resp_valid is high; 1 = timeout
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  latched address
mem_wen  out  1  latched write enable (always 0 for IFU)
mem_wdata  out  32  latched write data (0 for IFU)
mem_wmask  out  4  latched mask (0 for IFU)
mem_resp_valid  in  1  memory response
mem_rdata  in  32  memory read data

Behaviour:
- Reset: state IDLE, streak = 0, timeout counter = 0, owner = IFU. All registered outputs are 0. Both req_ready outputs are forced 0 while rst is high. Any in-flight transaction is dropped with no response.
- States:
  - IDLE -> REQ: when the granted master's req_valid is high. That master's req_ready is high for that single cycle (combinational: state == IDLE and grant). The request fields and owner are latched.
  - REQ: mem_req_valid = 1 with the latched fields held stable. On mem_req_ready -> RESP, with the counter cleared.
  - RESP -> DONE:
    - On mem_resp_valid: latch mem_rdata (forced 0 if the latched wen = 1); err = 0.
    - Else, if the counter == TIMEOUT-1: rdata = 0, err = 1.
    - Else the counter increments.
  - DONE: the owner's resp_valid = 1 for exactly this cycle, with rdata and resp_err valid. Next state is IDLE. Nothing is accepted in DONE.
- Grant (evaluated in IDLE only):
  - Only one requester: it wins.
  - Both requesting: LSU wins unless streak == MAX_LSU_STREAK, in which case IFU wins.
- Streak counter:
  - +1 on an LSU grant while ifu_req_valid is high.
  - Cleared on any IFU grant.
  - Unchanged on an uncontested LSU grant.
  - Saturates at MAX_LSU_STREAK.
- Minimum latency (memory ready and responding immediately): accept at cycle N, mem_req_valid at N+1, mem_resp_valid at N+2, resp_valid at N+3. Back-to-back accept at N+4.
- mem_resp_valid while in IDLE, REQ or DONE (e.g. after a timeout) is ignored.
- Requesters must hold req_valid and fields until req_ready. Dropping req_valid before grant is legal and is simply not served.
- Unused resp outputs hold 0. rdata outputs hold their last value only during DONE, otherwise 0.

Decomposition:
- Shared package: arb_state_t enum {IDLE, REQ, RESP, DONE}, owner_t enum {OWN_IFU, OWN_LSU}, bus width constants (ADDR_W = 32, DATA_W = 32, MASK_W = 4).
- One combinational sub-module, mem_arb_pick: inputs are both req_valid bits and streak_full; outputs are a one-hot grant. The FSM, latches, streak counter and watchdog stay in mem_arbiter.

Test Plan:
- IFU-only read: addr 0x80000000, memory ready immediately, rdata 0x00000413 -> ifu_resp_valid at cycle N+3, ifu_rdata 0x00000413, resp_err 0, mem_wen 0.
- LSU sw: addr 0x80001000, wdata 0xDEADBEEF, mask 4'b1111, memory ready after 3 cycles -> mem fields held stable during REQ; lsu_resp_valid pulse; lsu_rdata 0.
- Contention: both request continuously with MAX_LSU_STREAK = 4 -> grant order LSU ×4, IFU, LSU ×4, IFU.
- Timeout: mem_req_ready = 1, mem_resp_valid never asserted, TIMEOUT = 8 -> lsu_resp_valid with resp_err 1 and rdata 0 after 8 RESP cycles; a late mem_resp_valid is ignored.
- Reset mid-RESP: assert rst asynchronously -> all outputs 0 immediately, state IDLE, no resp pulse; after release, a new IFU request completes normally.
